// File: rtl/bus_memory_ws_if.sv
// ============================================================================
// bus_memory_ws_if : maxicore32 memory bus (request, strobes, ready/error)
// Revision 1.0
// ============================================================================
`default_nettype none

interface bus_memory_ws_if;
  logic [29:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        ready;
  logic        bus_error;

  modport master (
    output address,
    output data_in,
    output data_strobes,
    output read,
    output write,
    input  data_out,
    input  ready,
    input  bus_error
  );

  modport slave (
    input  address,
    input  data_in,
    input  data_strobes,
    input  read,
    input  write,
    output data_out,
    output ready,
    output bus_error
  );
endinterface

`default_nettype wire

// File: rtl/bus_memory_ws.sv
// ============================================================================
// bus_memory_ws : byte-strobed word RAM with wait states and bus_error reply
// Revision 1.0
// ============================================================================
`default_nettype none

module bus_memory_ws #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  wire logic      clock_i,
  input  wire logic      reset_ni,
  bus_memory_ws_if.slave bus
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);
  localparam logic [7:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 8'd0 : 8'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic [AW-1:0] index_q;
  logic [31:0] wdata_q;
  logic [3:0]  strobe_q;
  logic        write_q;
  logic [31:0] data_out_q;
  logic        ready_q;
  logic        bus_error_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [29:0] index_d;
  logic        in_range_d;
  logic        request_d;
  logic        reject_d;
  logic        mem_we_d;

  // Subtraction wraps for addresses below the base, so one compare covers both ends.
  assign index_d    = bus.address - BASE_WORD;
  assign in_range_d = (index_d < DEPTH_W30);
  assign request_d  = bus.read | bus.write;
  assign reject_d   = (bus.read & bus.write) | ~in_range_d | (bus.data_strobes == 4'b0000);
  assign mem_we_d   = reset_ni & (state_q == ST_ACCESS) & write_q;

  // RAM has no reset; a reset coinciding with the access edge suppresses the write.
  always_ff @(posedge clock_i) begin
    if (mem_we_d) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_q[b]) begin
          mem_q[index_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      index_q     <= '0;
      wdata_q     <= 32'd0;
      strobe_q    <= 4'd0;
      write_q     <= 1'b0;
      data_out_q  <= 32'd0;
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (request_d) begin
            if (reject_d) begin
              bus_error_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              index_q  <= index_d[AW-1:0];
              wdata_q  <= bus.data_in;
              strobe_q <= bus.data_strobes;
              write_q  <= bus.write;
              if (WAIT_STATES == 0) begin
                state_q <= ST_ACCESS;
              end else begin
                wait_cnt_q <= WAIT_LOAD;
                state_q    <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 8'd0) begin
            state_q <= ST_ACCESS;
          end else begin
            wait_cnt_q <= wait_cnt_q - 8'd1;
          end
        end
        ST_ACCESS: begin
          ready_q <= 1'b1;
          if (!write_q) begin
            data_out_q <= mem_q[index_q];
          end
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.ready     = ready_q;
  assign bus.bus_error = bus_error_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_memory_ws.sv
// ============================================================================
// tb_bus_memory_ws : scoreboarded bench over four differently-parameterised memories
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bus_memory_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        rst_n;
  logic [3:0][29:0]  addr_s;
  logic [3:0][31:0]  din_s;
  logic [3:0][3:0]   strb_s;
  logic [3:0]        rd_s;
  logic [3:0]        wr_s;
  logic [3:0][31:0]  dout_s;
  logic [3:0]        rdy_s;
  logic [3:0]        err_s;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_rdy_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance k: 0 -> 0 waits, 1 -> 3 waits, 2 -> 5 waits, 3 -> 1 wait, 16 words at byte 0x40.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    bus_memory_ws_if bus ();
    assign bus.address      = addr_s[g];
    assign bus.data_in      = din_s[g];
    assign bus.data_strobes = strb_s[g];
    assign bus.read         = rd_s[g];
    assign bus.write        = wr_s[g];
    assign dout_s[g]        = bus.data_out;
    assign rdy_s[g]         = bus.ready;
    assign err_s[g]         = bus.bus_error;

    bus_memory_ws #(
      .DEPTH_WORDS ((g == 3) ? 16 : 1024),
      .BASE_ADDR   ((g == 3) ? 32'h0000_0040 : 32'h0000_0000),
      .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 1),
      .INIT_FILE   ("")
    ) u_dut (
      .clock_i  (clk),
      .reset_ni (rst_n[g]),
      .bus      (bus)
    );
  end

  function automatic int ws_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      2:       return 5;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    bit          rd;
    bit          wr;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          err;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    bit          err;
    logic [31:0] dout;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Latency counts rising edges after the sampling edge until the reply is visible.
  task automatic access(input int k, input bit rd, input bit wr, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] s, input bit e_err,
                        input logic [31:0] e_dout, input bit hold);
    exp_t e;
    int   n;
    bit   got;
    sb.push_back('{err: e_err, dout: e_dout, lat: (e_err ? 0 : ws_of(k) + 1)});
    @(negedge clk);
    addr_s[k] = a;
    din_s[k]  = d;
    strb_s[k] = s;
    rd_s[k]   = rd;
    wr_s[k]   = wr;
    n   = -1;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy_s[k] | err_s[k]) got = 1'b1;
    end
    e = sb.pop_front();
    chk("response_seen", 32'(got), 32'd1);
    chk("bus_error", 32'(err_s[k]), 32'(e.err));
    chk("ready", 32'(rdy_s[k]), 32'(!e.err));
    chk("latency", 32'(n), 32'(e.lat));
    chk("data_out", dout_s[k], e.dout);
    if (rdy_s[k]) last_rdy_cyc = cyc;
    @(negedge clk);
    if (!hold) begin
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("pulse_width", {30'd0, rdy_s[k], err_s[k]}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1;
    rst_n  = 4'b0000;
    rd_s   = 4'b0000;
    wr_s   = 4'b0000;
    addr_s = '0;
    din_s  = '0;
    strb_s = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("reset_data_out", dout_s[k], 32'd0);
      chk("reset_ready_error", {30'd0, rdy_s[k], err_s[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 4'b1111;

    // Zero-wait instance: data path, strobes and every rejection reason.
    tv.push_back('{1'b0, 1'b1, 30'd0,          32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000});
    tv.push_back('{1'b1, 1'b0, 30'd0,          32'h00000000, 4'hF, 1'b0, 32'hDEADBEEF});
    tv.push_back('{1'b0, 1'b1, 30'd0,          32'h11223344, 4'h5, 1'b0, 32'hDEADBEEF});
    tv.push_back('{1'b1, 1'b0, 30'd0,          32'h00000000, 4'h1, 1'b0, 32'hDE22BE44});
    tv.push_back('{1'b1, 1'b0, 30'd1024,       32'h00000000, 4'hF, 1'b1, 32'hDE22BE44});
    tv.push_back('{1'b1, 1'b1, 30'd0,          32'h00000000, 4'hF, 1'b1, 32'hDE22BE44});
    tv.push_back('{1'b0, 1'b1, 30'd0,          32'h00000000, 4'h0, 1'b1, 32'hDE22BE44});
    tv.push_back('{1'b1, 1'b0, 30'd0,          32'h00000000, 4'h0, 1'b1, 32'hDE22BE44});
    tv.push_back('{1'b1, 1'b0, 30'd0,          32'h00000000, 4'hF, 1'b0, 32'hDE22BE44});
    tv.push_back('{1'b0, 1'b1, 30'd1023,       32'h01234567, 4'hF, 1'b0, 32'hDE22BE44});
    tv.push_back('{1'b0, 1'b1, 30'd1023,       32'hFFFFFFFF, 4'h2, 1'b0, 32'hDE22BE44});
    tv.push_back('{1'b1, 1'b0, 30'd1023,       32'h00000000, 4'hF, 1'b0, 32'h0123FF67});
    tv.push_back('{1'b1, 1'b0, 30'h3FFFFFFF,   32'h00000000, 4'hF, 1'b1, 32'h0123FF67});
    tv.push_back('{1'b0, 1'b1, 30'd0,          32'h99000000, 4'h8, 1'b0, 32'h0123FF67});
    tv.push_back('{1'b1, 1'b0, 30'd0,          32'h00000000, 4'hF, 1'b0, 32'h9922BE44});
    for (int i = 0; i < tv.size(); i++) begin
      access(0, tv[i].rd, tv[i].wr, tv[i].a, tv[i].d, tv[i].s, tv[i].err, tv[i].dout, 1'b0);
    end

    // Three wait states: reads complete on the fourth edge, errors stay immediate.
    access(1, 1'b0, 1'b1, 30'd5,    32'h55AA55AA, 4'hF, 1'b0, 32'h00000000, 1'b0);
    access(1, 1'b1, 1'b0, 30'd5,    32'h00000000, 4'hF, 1'b0, 32'h55AA55AA, 1'b0);
    access(1, 1'b1, 1'b0, 30'd1024, 32'h00000000, 4'hF, 1'b1, 32'h55AA55AA, 1'b0);
    access(1, 1'b1, 1'b0, 30'd5,    32'h00000000, 4'h0, 1'b1, 32'h55AA55AA, 1'b0);

    // Five wait states: reset lands two clocks into a write, which must be abandoned.
    access(2, 1'b0, 1'b1, 30'd7, 32'h12345678, 4'hF, 1'b0, 32'h00000000, 1'b0);
    access(2, 1'b1, 1'b0, 30'd7, 32'h00000000, 4'hF, 1'b0, 32'h12345678, 1'b0);
    @(negedge clk);
    addr_s[2] = 30'd7;
    din_s[2]  = 32'hCAFEF00D;
    strb_s[2] = 4'hF;
    wr_s[2]   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b0;
    #1;
    chk("midop_reset_data_out", dout_s[2], 32'd0);
    chk("midop_reset_ready_error", {30'd0, rdy_s[2], err_s[2]}, 32'd0);
    wr_s[2] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    access(2, 1'b1, 1'b0, 30'd7, 32'h00000000, 4'hF, 1'b0, 32'h12345678, 1'b0);

    // One wait state, base at word 0x10: request held into turnaround, then a new one.
    access(3, 1'b0, 1'b1, 30'h13, 32'h33333333, 4'hF, 1'b0, 32'h00000000, 1'b0);
    access(3, 1'b0, 1'b1, 30'h14, 32'h44444444, 4'hF, 1'b0, 32'h00000000, 1'b0);
    access(3, 1'b1, 1'b0, 30'h13, 32'h00000000, 4'hF, 1'b0, 32'h33333333, 1'b1);
    t1 = last_rdy_cyc;
    access(3, 1'b1, 1'b0, 30'h14, 32'h00000000, 4'hF, 1'b0, 32'h44444444, 1'b0);
    chk("ready_spacing_min", 32'((last_rdy_cyc - t1) >= (ws_of(3) + 2)), 32'd1);
    access(3, 1'b1, 1'b0, 30'h0F, 32'h00000000, 4'hF, 1'b1, 32'h44444444, 1'b0);
    access(3, 1'b1, 1'b0, 30'h20, 32'h00000000, 4'hF, 1'b1, 32'h44444444, 1'b0);
    access(3, 1'b1, 1'b0, 30'h1F, 32'h00000000, 4'h0, 1'b1, 32'h44444444, 1'b0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
